sync_fifo: RTL

- Parametrised single-clock FIFO. It is the single-domain successor to the team's dual-clock AFIFO and is used where producer and consumer share `clk`.
- Adds features the dual-clock FIFO lacks:
  - configurable width and depth
  - exact occupancy count
  - programmable almost-full and almost-empty thresholds
  - selectable combinational or registered read data
  - synchronous flush
  - sticky overflow and underflow error flags
- Sits between stream producers and consumers in the datapath, for example between sensor-readout and SD-write blocks.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_ram.sv | 25 ++
 rtl/sync_fifo.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO family: output-stage mode, error-bit
// layout and parameter-check utilities.
package fifo_pkg;

   typedef enum logic {
      FIFO_OUT_COMB = 1'b0,
      FIFO_OUT_REG  = 1'b1
   } fifo_outmode_t;

   localparam int ERR_OVF = 0;
   localparam int ERR_UDF = 1;
   localparam int ERR_W   = 2;

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Width x Size storage: synchronous write, asynchronous read, no reset.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int Width = 12,
   parameter int Size  = 4,
   localparam int AW   = $clog2(Size)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    wa,
   input  logic [Width-1:0] wd,
   input  logic [AW-1:0]    ra,
   output logic [Width-1:0] rd
);

   logic [Width-1:0] mem [Size];

   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end

   assign rd = mem[ra];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with exact level, almost thresholds, optional registered
// read stage, synchronous flush and sticky overflow/underflow flags.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int Width       = 12,
   parameter int Size        = 4,
   parameter int AlmostFull  = 3,
   parameter int AlmostEmpty = 1,
   parameter int OutReg      = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    w,
   input  logic [Width-1:0]        wd,
   output logic                    wfull,
   output logic                    walmostfull,
   input  logic                    r,
   output logic [Width-1:0]        rd,
   output logic                    rempty,
   output logic                    ralmostempty,
   output logic [$clog2(Size):0]   level,
   output logic                    overflow,
   output logic                    underflow,
   input  logic                    errclr
);

   localparam int AW = $clog2(Size);
   localparam int PW = AW + 1;
   localparam fifo_outmode_t MODE = (OutReg != 0) ? FIFO_OUT_REG : FIFO_OUT_COMB;

   if (!is_pow2(Size) || Size < 2) begin : g_size_chk
      $error("sync_fifo: Size=%0d must be a power of 2 and >= 2", Size);
   end
   if (AlmostFull < 1 || AlmostFull > Size || AlmostEmpty < 0 || AlmostEmpty >= AlmostFull) begin : g_thr_chk
      $error("sync_fifo: need 1<=AlmostFull<=Size and 0<=AlmostEmpty<AlmostFull");
   end

   logic [PW-1:0]    wptr, rptr, level_q, level_nxt;
   logic [Width-1:0] mem_rd, odata;
   logic             ovld, ovld_nxt;
   logic             full_q, afull_q, aempty_q, empty_q;
   logic             wr_acc, rd_acc, mem_pop, mem_avail;
   logic [ERR_W-1:0] err_q, err_set;

   fifo_ram #(.Width(Width), .Size(Size)) u_ram (
      .clk (clk),
      .we  (wr_acc),
      .wa  (wptr[AW-1:0]),
      .wd  (wd),
      .ra  (rptr[AW-1:0]),
      .rd  (mem_rd)
   );

   assign wr_acc    = w & ~full_q & ~flush;
   assign rd_acc    = r & ~empty_q & ~flush;
   assign mem_avail = (wptr != rptr);

   // In registered mode memory is drained into the output word whenever that
   // word is absent or leaving; in comb mode the head is consumed directly.
   always_comb begin
      mem_pop  = rd_acc;
      ovld_nxt = 1'b0;
      if (MODE == FIFO_OUT_REG) begin
         mem_pop  = mem_avail & (~ovld | rd_acc) & ~flush;
         ovld_nxt = ovld;
         if (flush)        ovld_nxt = 1'b0;
         else if (mem_pop) ovld_nxt = 1'b1;
         else if (rd_acc)  ovld_nxt = 1'b0;
      end
   end

   always_comb begin
      level_nxt = level_q;
      if (flush)                  level_nxt = '0;
      else if (wr_acc && !rd_acc) level_nxt = level_q + PW'(1);
      else if (rd_acc && !wr_acc) level_nxt = level_q - PW'(1);
   end

   always_comb begin
      err_set          = '0;
      err_set[ERR_OVF] = w & full_q;
      err_set[ERR_UDF] = r & empty_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         empty_q  <= 1'b1;
         ovld     <= 1'b0;
         odata    <= '0;
         err_q    <= '0;
      end else begin
         level_q  <= level_nxt;
         full_q   <= (level_nxt == PW'(Size));
         afull_q  <= (level_nxt >= PW'(AlmostFull));
         aempty_q <= (level_nxt <= PW'(AlmostEmpty));
         empty_q  <= (MODE == FIFO_OUT_REG) ? ~ovld_nxt : (level_nxt == '0);
         ovld     <= ovld_nxt;
         // A new error event wins over a same-cycle clear.
         err_q    <= (errclr ? '0 : err_q) | err_set;
         if (flush) begin
            wptr <= '0;
            rptr <= '0;
         end else begin
            if (wr_acc)  wptr <= wptr + PW'(1);
            if (mem_pop) rptr <= rptr + PW'(1);
            if (MODE == FIFO_OUT_REG && mem_pop) odata <= mem_rd;
         end
      end
   end

   assign rd           = (MODE == FIFO_OUT_REG) ? odata : mem_rd;
   assign rempty       = empty_q;
   assign wfull        = full_q;
   assign walmostfull  = afull_q;
   assign ralmostempty = aempty_q;
   assign level        = level_q;
   assign overflow     = err_q[ERR_OVF];
   assign underflow    = err_q[ERR_UDF];

   a_level_range: assert property (@(posedge clk) disable iff (!rst_n) level_q <= PW'(Size));

   if (MODE == FIFO_OUT_COMB) begin : g_comb_chk
      a_empty_level: assert property (@(posedge clk) disable iff (!rst_n) empty_q == (level_q == '0));
   end

endmodule
